// File: rtl/decode_div_pkg.sv
// decode_div_pkg: FSM state type, steps-per-cycle and latency helper for the sequential signed divider.
// Build option: DECODE_SDIV_RADIX4_EN selects two quotient bits per CALC cycle (default one).
package decode_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
`ifdef DECODE_SDIV_RADIX4_EN
  localparam int DIV_STEPS_PER_CYC = 2;
`else
  localparam int DIV_STEPS_PER_CYC = 1;
`endif
  function automatic int div_latency(input int n);
    return n / DIV_STEPS_PER_CYC + 2;
  endfunction
endpackage

// File: rtl/decode_sdiv_step.sv
// decode_sdiv_step: one combinational restoring shift-compare-subtract step on unsigned magnitudes.
// Ports: rem_i partial remainder, bit_i next dividend bit, dvs_i divisor magnitude,
//        rem_o updated remainder, q_o quotient bit.
module decode_sdiv_step #(
  parameter int W = 33
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);
  logic [W:0] sh;
  logic [W:0] df;
  assign sh    = {rem_i, bit_i};
  assign df    = sh - {1'b0, dvs_i};
  assign q_o   = sh >= {1'b0, dvs_i};
  assign rem_o = q_o ? df[W-1:0] : sh[W-1:0];
endmodule

// File: rtl/decode_sdiv_70s_33s_seq.sv
// decode_sdiv_70s_33s_seq: iterative signed divider, quotient truncated toward zero, start/done handshake.
// Ports: clk, reset (async active-low), ce (clock enable), start, dividend, divisor ->
//        busy, done (one-cycle pulse), quo, rem (sign of dividend), div0 (divisor was zero).
// Build option: DECODE_SDIV_RADIX4_EN chains two steps per CALC cycle; results are identical.
module decode_sdiv_70s_33s_seq
  import decode_div_pkg::*;
#(
  parameter int ID             = 1,
  parameter int DIVIDEND_WIDTH = 70,
  parameter int DIVISOR_WIDTH  = 33
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      busy,
  output logic                      done,
  output logic [DIVIDEND_WIDTH-1:0] quo,
  output logic [DIVISOR_WIDTH-1:0]  rem,
  output logic                      div0
);
  localparam int N     = DIVIDEND_WIDTH;
  localparam int M     = DIVISOR_WIDTH;
  localparam int ITERS = N / DIV_STEPS_PER_CYC;
  localparam int CW    = $clog2(ITERS);
  div_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // q_q shifts dividend magnitude out of the top while quotient bits enter at the bottom
  logic [N-1:0] q_q, q_d, q_step, a_abs, quo_q, quo_d;
  logic [M-1:0] r_q, r_d, r_step, d_q, d_d, d_abs, rem_q, rem_d, r1;
  logic qneg_q, qneg_d, rneg_q, rneg_d, z_q, z_d, done_q, done_d, div0_q, div0_d, b1;
  assign a_abs = dividend[N-1] ? -dividend : dividend;
  assign d_abs = divisor[M-1] ? -divisor : divisor;
  decode_sdiv_step #(.W(M)) u_s0 (.rem_i(r_q), .bit_i(q_q[N-1]), .dvs_i(d_q), .rem_o(r1), .q_o(b1));
`ifdef DECODE_SDIV_RADIX4_EN
  logic [M-1:0] r2;
  logic b2;
  decode_sdiv_step #(.W(M)) u_s1 (.rem_i(r1), .bit_i(q_q[N-2]), .dvs_i(d_q), .rem_o(r2), .q_o(b2));
  assign q_step = {q_q[N-3:0], b1, b2};
  assign r_step = r2;
`else
  assign q_step = {q_q[N-2:0], b1};
  assign r_step = r1;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    z_d     = z_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div0_d  = div0_q;
    done_d  = done_q;
    if (ce) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_d = CALC;
          cnt_d   = CW'(ITERS - 1);
          q_d     = a_abs;
          r_d     = '0;
          d_d     = d_abs;
          qneg_d  = dividend[N-1] ^ divisor[M-1];
          rneg_d  = dividend[N-1];
          z_d     = divisor == '0;
        end
        CALC: begin
          q_d     = q_step;
          r_d     = r_step;
          cnt_d   = cnt_q - 1'b1;
          state_d = cnt_q == '0 ? FIX : CALC;
        end
        // A zero divisor leaves |dividend| low bits in r_q; re-signing yields dividend[M-1:0]
        FIX: begin
          q_d     = z_q ? '1 : (qneg_q ? -q_q : q_q);
          r_d     = rneg_q ? -r_q : r_q;
          state_d = DONE;
        end
        DONE: begin
          quo_d   = q_q;
          rem_d   = r_q;
          div0_d  = z_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      z_q     <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      z_q     <= z_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign div0 = div0_q;
endmodule

// File: tb/tb_decode_sdiv_70s_33s_seq.sv
// tb_decode_sdiv_70s_33s_seq: scoreboard bench for the sequential signed divider.
module tb_decode_sdiv_70s_33s_seq;
  import decode_div_pkg::*;
  localparam int L = div_latency(70);
  typedef struct {
    logic [69:0] q;
    logic [32:0] r;
    logic        z;
    string       nm;
  } exp_t;
  logic clk, reset, ce, start, busy, done, div0;
  logic [69:0] dividend, quo;
  logic [32:0] divisor, rem;
  exp_t sb[$];
  int n_chk, n_fail;
  decode_sdiv_70s_33s_seq dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quo(quo), .rem(rem), .div0(div0)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic void chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction
  always @(negedge clk) begin
    if (reset && done && ce) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_done: got done=1 expected no pending result");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, " quo"}, quo, e.q);
        chk({e.nm, " rem"}, 70'(rem), 70'(e.r));
        chk({e.nm, " div0"}, 70'(div0), 70'(e.z));
      end
    end
  end
  task automatic run(input logic signed [69:0] a, input logic signed [32:0] b, input logic [69:0] eq,
                     input logic [32:0] er, input logic ez, input string nm, input bit rp, input int lo);
    int lat;
    sb.push_back('{q: eq, r: er, z: ez, nm: nm});
    dividend = a;
    divisor  = b;
    start    = 1;
    ce       = 1;
    @(posedge clk); #1;
    lat = 0;
    start = 0;
    while (!done && lat < 300) begin
      if (lat == 1) chk({nm, " busy"}, 70'(busy), 70'd1);
      start = rp && (lat == 5 || lat == L - 1);
      if (start) begin
        dividend = 70'd999;
        divisor  = 33'd1;
      end
      ce = !(lo > 0 && lat >= 20 && lat < 20 + lo);
      @(posedge clk); #1;
      lat++;
    end
    start = 0;
    ce    = 1;
    chk({nm, " latency"}, 70'(lat), 70'(L + lo));
    chk({nm, " busy_at_done"}, 70'(busy), 70'd0);
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic signed [69:0] mn, ra, rq, rr;
    logic signed [32:0] rb;
    logic [95:0] t;
    n_chk = 0;
    n_fail = 0;
    reset = 0;
    ce = 1;
    start = 0;
    dividend = '0;
    divisor = '0;
    mn = {1'b1, 69'b0};
    #12;
    chk("reset busy", 70'(busy), 70'd0);
    chk("reset done", 70'(done), 70'd0);
    chk("reset quo", quo, 70'd0);
    chk("reset rem", 70'(rem), 70'd0);
    chk("reset div0", 70'(div0), 70'd0);
    @(posedge clk); #1;
    reset = 1;
    run(100, 7, 14, 2, 0, "p_div_p", 0, 0);
    run(-100, 7, -14, -2, 0, "n_div_p", 0, 0);
    run(100, -7, -14, 2, 0, "p_div_n", 0, 0);
    run(-100, -7, 14, -2, 0, "n_div_n", 0, 0);
    run(12345, 0, {70{1'b1}}, 12345, 1, "div_zero", 0, 0);
    run(mn, -1, mn, 0, 0, "min_neg_ovf", 0, 0);
    run(70'd4294967295, {1'b1, 32'b0}, 0, 33'h0FFFFFFFF, 0, "ext_divisor", 0, 0);
    run(1000, 3, 333, 1, 0, "start_ignored", 1, 0);
    run(1000, -3, -333, 1, 0, "ce_stall", 0, 10);
    dividend = 77;
    divisor = 3;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (20) @(posedge clk);
    #3;
    reset = 0;
    #1;
    chk("abort busy", 70'(busy), 70'd0);
    chk("abort done", 70'(done), 70'd0);
    chk("abort quo", quo, 70'd0);
    chk("abort rem", 70'(rem), 70'd0);
    chk("abort div0", 70'(div0), 70'd0);
    @(posedge clk); #1;
    reset = 1;
    repeat (100) @(posedge clk);
    #1;
    chk("abort quiet quo", quo, 70'd0);
    run(50, 5, 10, 0, 0, "after_abort", 0, 0);
    for (int i = 0; i < 200; i++) begin
      t = {$urandom(), $urandom(), $urandom()};
      ra = t[69:0];
      ra = ra >>> $urandom_range(0, 69);
      t = {$urandom(), $urandom(), $urandom()};
      rb = t[32:0];
      rb = rb >>> $urandom_range(0, 32);
      if (rb == 0) rb = 1;
      if (ra == mn && rb == -1) rb = 3;
      rq = ra / rb;
      rr = ra % rb;
      run(ra, rb, rq, rr[32:0], 0, "random", 0, 0);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 70'(sb.size()), 70'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
